lfsr_sequence_checker: RTL and testbench

Receiving end of the 8-bit Galois LFSR stream produced by the random number generator. It samples the generator's full 8-bit state word and self-synchronises to the sequence. It then predicts each next word, reports lock, and counts sequence errors. It is used as on-board self-check of generators and as the verification companion in lab testbenches.

---
 rtl/lfsr_sequence_checker_pkg.sv | 21 ++
 rtl/lfsr_sequence_checker_if.sv | 28 ++
 rtl/lfsr_sequence_checker_sat_counter.sv | 21 ++
 rtl/lfsr_sequence_checker.sv | 145 ++++++++++++++
 tb/tb_lfsr_sequence_checker.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_sequence_checker_pkg.sv
// Shared definitions for the 8-bit Galois LFSR generator and its checker.
//   state_t    : checker FSM states
//   LFSR_W     : LFSR word width
//   lfsr_next  : one-step next-state function. Generator and checker both call it
//                so that the two ends use the same polynomial.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 8;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    // Galois step: shift right, bit 0 wraps to bit 7 and also feeds taps 3..1.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[0], s[7], s[6], s[5], s[0] ^ s[4], s[0] ^ s[3], s[0] ^ s[2], s[1]};
    endfunction

endpackage

// File: rtl/lfsr_sequence_checker_if.sv
// Sample and status bundle of the LFSR sequence checker.
//   in_valid, in_state            : sample stream (master -> slave)
//   locked, err_pulse, err_count,
//   zero_err, seed_seen           : status (slave -> master)
// The master modport is the stream source; the slave modport is the checker.
interface lfsr_sequence_checker_if #(
    parameter int unsigned CNT_W = 16
) ();
    import lfsr_pkg::*;

    logic              in_valid;
    logic [LFSR_W-1:0] in_state;
    logic              locked;
    logic              err_pulse;
    logic [CNT_W-1:0]  err_count;
    logic              zero_err;
    logic              seed_seen;

    modport master (
        output in_valid, in_state,
        input  locked, err_pulse, err_count, zero_err, seed_seen
    );

    modport slave (
        input  in_valid, in_state,
        output locked, err_pulse, err_count, zero_err, seed_seen
    );
endinterface

// File: rtl/lfsr_sequence_checker_sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   rst   : synchronous active-low clear
//   en    : increment request; ignored once the count is all-ones
//   count : current value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/lfsr_sequence_checker.sv
// Receiver-side checker for the 8-bit Galois LFSR stream. Self-synchronises to
// the sampled state words, predicts each next word, reports lock and counts
// mispredictions while locked.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : slave side of lfsr_sequence_checker_if (sample in, status out)
// All status outputs change only on the cycle after a valid sample.
module lfsr_sequence_checker
    import lfsr_pkg::*;
#(
    parameter logic [7:0]  SEED        = 8'h01,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned LOSS_THRESH = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    lfsr_sequence_checker_if.slave bus
);
    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_THRESH);

    state_t            state_q, state_d;
    logic [LFSR_W-1:0] pred_q, pred_d;
    logic [3:0]        match_cnt_q, match_cnt_d;
    logic [3:0]        miss_cnt_q, miss_cnt_d;
    logic              err_pulse_q, err_pulse_d;
    logic              zero_err_q, zero_err_d;
    logic              seed_seen_q, seed_seen_d;
    logic [CNT_W-1:0]  err_count;

    logic       is_zero;
    logic       is_match;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;

    assign is_zero   = (bus.in_state == '0);
    assign is_match  = (bus.in_state == pred_q);
    assign match_inc = match_cnt_q + 4'd1;
    assign miss_inc  = miss_cnt_q + 4'd1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    if (!is_zero) state_d = VERIFY;
                end
                VERIFY: begin
                    if (is_zero)                              state_d = HUNT;
                    else if (is_match && match_inc == LOCK_C) state_d = LOCKED;
                end
                LOCKED: begin
                    if (!is_match && miss_inc == LOSS_C) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output / datapath next values
    always_comb begin
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_pulse_d = 1'b0;
        zero_err_d  = 1'b0;
        seed_seen_d = 1'b0;
        if (bus.in_valid) begin
            zero_err_d  = is_zero;
            seed_seen_d = (bus.in_state == SEED);
            case (state_q)
                HUNT: begin
                    if (!is_zero) begin
                        pred_d      = lfsr_next(bus.in_state);
                        match_cnt_d = '0;
                    end
                end
                VERIFY: begin
                    match_cnt_d = '0;
                    if (!is_zero) begin
                        // A mismatch re-seeds from the sample itself.
                        pred_d = lfsr_next(bus.in_state);
                        if (is_match) match_cnt_d = match_inc;
                    end
                    miss_cnt_d = '0;
                end
                LOCKED: begin
                    if (is_match) begin
                        pred_d     = lfsr_next(bus.in_state);
                        miss_cnt_d = '0;
                    end else begin
                        // Freewheel on our own prediction; a zero sample lands here too.
                        err_pulse_d = 1'b1;
                        pred_d      = lfsr_next(pred_q);
                        miss_cnt_d  = (miss_inc == LOSS_C) ? 4'd0 : miss_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_pulse_q <= 1'b0;
            zero_err_q  <= 1'b0;
            seed_seen_q <= 1'b0;
        end else begin
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_pulse_q <= err_pulse_d;
            zero_err_q  <= zero_err_d;
            seed_seen_q <= seed_seen_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (err_pulse_d),
        .count (err_count)
    );

    assign bus.locked    = (state_q == LOCKED);
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_count = err_count;
    assign bus.zero_err  = zero_err_q;
    assign bus.seed_seen = seed_seen_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
module tb_lfsr_sequence_checker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests_run = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    // Hand-derived chain from 8'h01 (each step: (s>>1) ^ (s[0] ? 8E : 00)).
    logic [7:0] seq [0:20] = '{8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36,
                               8'h1B, 8'h83, 8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0,
                               8'h58, 8'h2C, 8'h16, 8'h0B, 8'h8B, 8'hCB, 8'hEB};

    lfsr_sequence_checker_if #(.CNT_W(16)) bus ();
    lfsr_sequence_checker_if #(.CNT_W(4))  sbus ();

    lfsr_sequence_checker #(
        .SEED(8'h01), .LOCK_COUNT(4), .LOSS_THRESH(3), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    lfsr_sequence_checker #(
        .SEED(8'h01), .LOCK_COUNT(4), .LOSS_THRESH(15), .CNT_W(4)
    ) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus.slave)
    );

    task automatic sample(input logic v, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_state = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic sample_s(input logic v, input logic [7:0] d);
        sbus.in_valid = v;
        sbus.in_state = d;
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        sbus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic lock_main();
        for (int i = 0; i < 5; i++) sample(1'b1, seq[i]);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_state = 8'h01;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.zero_err !== 1'b0 ||
            bus.seed_seen !== 1'b0 || bus.err_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs got locked=%b err=%b zero=%b seed=%b cnt=%h, want all 0",
                     bus.locked, bus.err_pulse, bus.zero_err, bus.seed_seen, bus.err_count);
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_lock_from_seed();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sample(1'b1, seq[i]);
            tests_run++;
            if (bus.locked !== (i == 4)) begin
                fails++;
                $display("FAIL lock_seed_locked[%0d] got %b want %b", i, bus.locked, (i == 4));
            end
            tests_run++;
            if (bus.seed_seen !== (i == 0)) begin
                fails++;
                $display("FAIL lock_seed_seen[%0d] got %b want %b", i, bus.seed_seen, (i == 0));
            end
        end
        tests_run++;
        if (bus.err_count !== 16'h0 || bus.err_pulse !== 1'b0) begin
            fails++;
            $display("FAIL lock_seed_noerr got cnt=%h pulse=%b want 0/0", bus.err_count, bus.err_pulse);
        end
    endtask

    task automatic test_single_error();
        do_reset();
        lock_main();
        sample(1'b1, 8'h00);
        tests_run++;
        if (bus.zero_err !== 1'b1 || bus.err_pulse !== 1'b1 || bus.err_count !== 16'd1 ||
            bus.locked !== 1'b1) begin
            fails++;
            $display("FAIL single_err_inject got zero=%b err=%b cnt=%h locked=%b want 1/1/0001/1",
                     bus.zero_err, bus.err_pulse, bus.err_count, bus.locked);
        end
        for (int i = 6; i < 9; i++) begin
            sample(1'b1, seq[i]);
            tests_run++;
            if (bus.zero_err !== 1'b0 || bus.err_pulse !== 1'b0 || bus.err_count !== 16'd1 ||
                bus.locked !== 1'b1) begin
                fails++;
                $display("FAIL single_err_resume[%0d] got zero=%b err=%b cnt=%h locked=%b want 0/0/0001/1",
                         i, bus.zero_err, bus.err_pulse, bus.err_count, bus.locked);
            end
        end
    endtask

    task automatic test_loss();
        do_reset();
        lock_main();
        for (int i = 0; i < 3; i++) begin
            sample(1'b1, 8'h55);
            tests_run++;
            if (bus.err_count !== 16'(i + 1) || bus.err_pulse !== 1'b1 || bus.locked !== (i < 2)) begin
                fails++;
                $display("FAIL loss_miss[%0d] got cnt=%h err=%b locked=%b want %h/1/%b",
                         i, bus.err_count, bus.err_pulse, bus.locked, 16'(i + 1), (i < 2));
            end
        end
        for (int j = 0; j < 5; j++) begin
            sample(1'b1, seq[5 + j]);
            tests_run++;
            if (bus.locked !== (j == 4) || bus.err_pulse !== 1'b0 || bus.err_count !== 16'd3) begin
                fails++;
                $display("FAIL loss_relock[%0d] got locked=%b err=%b cnt=%h want %b/0/0003",
                         j, bus.locked, bus.err_pulse, bus.err_count, (j == 4));
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sample(1'b1, seq[i]);
            tests_run++;
            if (bus.locked !== (i == 4) || bus.err_pulse !== 1'b0) begin
                fails++;
                $display("FAIL gaps_valid[%0d] got locked=%b err=%b want %b/0",
                         i, bus.locked, bus.err_pulse, (i == 4));
            end
            sample(1'b0, 8'h00);
            tests_run++;
            if (bus.locked !== (i == 4) || bus.zero_err !== 1'b0 || bus.seed_seen !== 1'b0 ||
                bus.err_pulse !== 1'b0) begin
                fails++;
                $display("FAIL gaps_idle[%0d] got locked=%b zero=%b seed=%b err=%b want %b/0/0/0",
                         i, bus.locked, bus.zero_err, bus.seed_seen, bus.err_pulse, (i == 4));
            end
        end
        tests_run++;
        if (bus.err_count !== 16'h0) begin
            fails++;
            $display("FAIL gaps_errcnt got %h want 0000", bus.err_count);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        lock_main();
        sample(1'b1, 8'h00);
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_state = 8'h01;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.locked !== 1'b0 || bus.err_pulse !== 1'b0 || bus.zero_err !== 1'b0 ||
            bus.seed_seen !== 1'b0 || bus.err_count !== 16'h0) begin
            fails++;
            $display("FAIL midlock_reset got locked=%b err=%b zero=%b seed=%b cnt=%h want all 0",
                     bus.locked, bus.err_pulse, bus.zero_err, bus.seed_seen, bus.err_count);
        end
        for (int j = 1; j < 6; j++) begin
            sample(1'b1, seq[j]);
            tests_run++;
            if (bus.locked !== (j == 5)) begin
                fails++;
                $display("FAIL midlock_relock[%0d] got locked=%b want %b", j, bus.locked, (j == 5));
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) sample_s(1'b1, seq[i]);
        tests_run++;
        if (sbus.locked !== 1'b1) begin
            fails++;
            $display("FAIL sat_lock got locked=%b want 1", sbus.locked);
        end
        for (int k = 1; k <= 10; k++) sample_s(1'b1, 8'h55);
        tests_run++;
        if (sbus.err_count !== 4'hA || sbus.locked !== 1'b1) begin
            fails++;
            $display("FAIL sat_ten got cnt=%h locked=%b want a/1", sbus.err_count, sbus.locked);
        end
        // Freewheeled prediction is now seq[15]; matching it clears the miss run.
        sample_s(1'b1, seq[15]);
        tests_run++;
        if (sbus.err_pulse !== 1'b0 || sbus.locked !== 1'b1 || sbus.err_count !== 4'hA) begin
            fails++;
            $display("FAIL sat_rematch got err=%b locked=%b cnt=%h want 0/1/a",
                     sbus.err_pulse, sbus.locked, sbus.err_count);
        end
        for (int k = 1; k <= 10; k++) begin
            sample_s(1'b1, 8'h55);
            want = (k >= 5) ? 4'hF : 4'(10 + k);
            tests_run++;
            if (sbus.err_count !== want || sbus.err_pulse !== 1'b1 || sbus.locked !== 1'b1) begin
                fails++;
                $display("FAIL sat_count[%0d] got cnt=%h err=%b locked=%b want %h/1/1",
                         k, sbus.err_count, sbus.err_pulse, sbus.locked, want);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_state  = 8'h00;
        sbus.in_valid = 1'b0;
        sbus.in_state = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_lock_from_seed();
        test_single_error();
        test_loss();
        test_gaps();
        test_reset_mid_lock();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
